arf_frame_driver: RTL
=====================

Name: arf_frame_driver

Overview:
- Driver end of the ARF datapath operand/result interface.
- Collects a serial stream of the 10 external ARF operands into a parallel frame and presents it to the ARF datapath (accurate or approximate variant).
- Waits the datapath latency, captures both filter outputs (out_27, out_28) and returns them as a 2-beat serial stream.
- Sits between the test/host stream fabric and the ARF core, so the combinational DFG benchmarks can be exercised and timed in a clocked environment.

Parameters:
- DATA_W, 16, width of every operand and result word.
- ARF_LAT, 0, clock cycles of ARF datapath latency (0 = combinational core). Range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  operand word valid.
- s_ready  out  1  driver accepts an operand word.
- s_data  in  DATA_W  operand word.
- s_last  in  1  marks the 10th word of a frame.
- frame_o  out  10*DATA_W  operand frame. Word k sits at bits [k*DATA_W +: DATA_W]. k=0..7 drive in_1_0..in_8_0; k=8 drives in_13_1; k=9 drives in_14_1.
- frame_valid_o  out  1  frame complete and stable; datapath outputs meaningful after ARF_LAT.
- res27_i  in  DATA_W  ARF out_27.
- res28_i  in  DATA_W  ARF out_28.
- m_valid  out  1  result word valid.
- m_ready  in  1  downstream accepts the result word.
- m_data  out  DATA_W  result word.
- m_last  out  1  high on the second result beat (out_28).
- frame_err  out  1  sticky framing error flag.
- frame_cnt  out  16  completed frames; wraps from 0xFFFF to 0.

Behaviour:
- Reset (asynchronous, active-high, any state): state=LOAD, index=0, frame_o=0, result regs=0, frame_cnt=0, frame_err=0, frame_valid_o=0, m_valid=0, m_data=0, m_last=0.
- s_ready is 1 only in LOAD, and is not a function of s_valid.
- Handshakes:
  - A beat transfers when valid&ready are high at a rising edge.
  - m_valid, once raised, stays high and m_data/m_last stay stable until m_ready.
- State machine:
  - LOAD:
    - Each accepted beat writes s_data into frame word[index], then index++.
    - If s_last=1 at index 9: index←0, wait_cnt←ARF_LAT, frame_valid_o←1, go WAIT.
    - If s_last=1 at index<9, or s_last=0 at index 9: frame_err←1, index←0, frame_valid_o stays 0, stay LOAD. frame_o words already written are not cleared.
  - WAIT:
    - If wait_cnt==0: capture res27_i/res28_i, go SEND0.
    - Otherwise decrement wait_cnt.
    - WAIT lasts exactly ARF_LAT+1 cycles.
  - SEND0: m_valid=1, m_data=captured out_27, m_last=0. On m_ready go SEND1.
  - SEND1: m_data=captured out_28, m_last=1. On m_ready: frame_cnt++, frame_valid_o←0, m_valid←0, go LOAD.
- Latency: with the 10th beat accepted at edge E, m_valid is high from edge E+1+ARF_LAT.
- frame_o holds its value from WAIT through SEND1. It changes only on LOAD accepts.
- frame_valid_o deasserts the same edge m_valid drops after the out_28 beat.
- No operand accepted outside LOAD; s_valid there is ignored (no error).
- frame_err is cleared only by rst.

Test Plan:
- DATA_W=16, ARF_LAT=0: stream words 1..10 (s_last on 10th) with m_ready=1 → frame_o words = 1..10. m_valid rises 1 cycle after the 10th accept, m_data=res27_i then res28_i with m_last on the 2nd beat. frame_cnt=1.
- ARF_LAT=3: same frame. Change res27_i/res28_i only at the 4th WAIT cycle → the values present on that cycle are captured; m_valid rises exactly 4 cycles after the last accept.
- Backpressure: m_ready=0 for 5 cycles in SEND0 → m_valid held, m_data stable, s_ready=0. After release, 2 beats emitted, then s_ready=1.
- Framing: s_last on the 4th word → frame_err=1, no m_valid. Next clean 10-word frame completes normally, frame_cnt increments, frame_err stays 1.
- Reset mid-WAIT (ARF_LAT=5, rst pulsed on 2nd WAIT cycle, asynchronous to clk) → all outputs return to reset values immediately, s_ready=1 after release, index restarts at 0.
- Wrap: preload 0xFFFF completed frames (force or long run) → next frame makes frame_cnt=0x0000.

Source files
------------

// File: rtl/arf_frame_driver.sv
// Driver shell for the ARF datapath: gathers a 10-word operand frame, waits the
// core latency, captures out_27/out_28 and returns them as a 2-beat result stream.
module arf_frame_driver #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ARF_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_last,
  output logic [10*DATA_W-1:0]  frame_o,
  output logic                  frame_valid_o,
  input  logic [DATA_W-1:0]     res27_i,
  input  logic [DATA_W-1:0]     res28_i,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_last,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_SEND0, ST_SEND1} state_e;

  localparam logic [3:0] LAT4 = 4'(ARF_LAT);

  state_e                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            wait_q, wait_d;
  logic [10*DATA_W-1:0]  frame_q, frame_d;
  logic [DATA_W-1:0]     r27_q, r27_d;
  logic [DATA_W-1:0]     r28_q, r28_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  err_q, err_d;
  logic                  fv_q, fv_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      wait_q      <= '0;
      frame_q     <= '0;
      r27_q       <= '0;
      r28_q       <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      fv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      frame_q     <= frame_d;
      r27_q       <= r27_d;
      r28_q       <= r28_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      fv_q        <= fv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    frame_d     = frame_q;
    r27_d       = r27_q;
    r28_d       = r28_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    fv_d        = fv_q;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          for (int unsigned k = 0; k < 10; k++) begin
            if (idx_q == k[3:0]) frame_d[k*DATA_W +: DATA_W] = s_data;
          end
          if (s_last && idx_q == 4'd9) begin
            idx_d   = '0;
            wait_d  = LAT4;
            fv_d    = 1'b1;
            state_d = ST_WAIT;
          end else if (s_last || idx_q == 4'd9) begin
            // Misframed: keep partially written words, restart at word 0.
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          r27_d   = res27_i;
          r28_d   = res28_i;
          state_d = ST_SEND0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_SEND0: begin
        m_valid = 1'b1;
        m_data  = r27_q;
        if (m_ready) state_d = ST_SEND1;
      end
      ST_SEND1: begin
        m_valid = 1'b1;
        m_data  = r28_q;
        m_last  = 1'b1;
        if (m_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          fv_d        = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign frame_o       = frame_q;
  assign frame_valid_o = fv_q;
  assign frame_err     = err_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
